// File: rtl/tow_round_ctrl.sv
// Tug-of-war round controller: pre-start delay, go cue, first-press arbitration,
// marker movement on an NLEDS-wide bar and a flashing win display.
module tow_round_ctrl #(
  parameter int NLEDS        = 7,
  parameter int DELAY_W      = 8,
  parameter int MIN_DELAY    = 16,
  parameter int PENALTY_MODE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [DELAY_W-1:0] rand_in,
  input  logic               pbl,
  input  logic               pbr,
  output logic [NLEDS-1:0]   led_out,
  output logic               go,
  output logic [1:0]         winner,
  output logic               match_over
);

  // state | meaning
  // HOLD  | waiting for both buttons to be released
  // WAIT  | random pre-start delay running; any press is a false start
  // GO    | go cue shown; first press scores
  // WIN   | marker reached an end; bar flashes until reset
  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_WAIT = 2'd1,
    S_GO   = 2'd2,
    S_WIN  = 2'd3
  } state_t;

  localparam int POS_W = $clog2(NLEDS);
  localparam int CNT_W = DELAY_W + 1;
  localparam logic [POS_W-1:0] CENTRE = POS_W'((NLEDS - 1) / 2);
  localparam logic [POS_W-1:0] LAST   = POS_W'(NLEDS - 1);

  state_t             state, state_nxt;
  logic [POS_W-1:0]   pos, pos_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               pbl_q, pbr_q;
  logic [1:0]         winner_q;
  logic               flash;
  logic               el, er;
  logic               mv_r, mv_l;
  logic               win_r, win_l;

  assign el = pbl & ~pbl_q;
  assign er = pbr & ~pbr_q;

  // Scoring decision for this cycle; a both-sides edge never moves the marker.
  always_comb begin
    mv_r = 1'b0;
    mv_l = 1'b0;
    case (state)
      S_WAIT: begin
        if (PENALTY_MODE != 0) begin
          mv_r = el & ~er;
          mv_l = er & ~el;
        end
      end
      S_GO: begin
        mv_r = er & ~el;
        mv_l = el & ~er;
      end
      default: ;
    endcase
  end

  always_comb begin
    pos_nxt = pos;
    if (mv_r)
      pos_nxt = pos + 1'b1;
    else if (mv_l)
      pos_nxt = pos - 1'b1;
  end

  assign win_r = mv_r & (pos_nxt == LAST);
  assign win_l = mv_l & (pos_nxt == '0);

  always_ff @(posedge clk) begin
    if (!rst)
      state <= S_HOLD;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HOLD: begin
        if (!(pbl | pbr))
          state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (el | er)
          state_nxt = (win_r | win_l) ? S_WIN : S_HOLD;
        else if (tick && cnt == CNT_W'(1))
          state_nxt = S_GO;
      end
      S_GO: begin
        if (el | er)
          state_nxt = (win_r | win_l) ? S_WIN : S_HOLD;
      end
      S_WIN: state_nxt = S_WIN;
      default: state_nxt = S_HOLD;
    endcase
  end

  // Edge registers reset high so a button held through reset yields no edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pos      <= CENTRE;
      cnt      <= '0;
      pbl_q    <= 1'b1;
      pbr_q    <= 1'b1;
      winner_q <= 2'b00;
      flash    <= 1'b0;
    end else begin
      pbl_q <= pbl;
      pbr_q <= pbr;
      pos   <= pos_nxt;
      if (state == S_HOLD && state_nxt == S_WAIT)
        cnt <= CNT_W'(MIN_DELAY) + CNT_W'(rand_in);
      else if (state == S_WAIT && tick && cnt != '0)
        cnt <= cnt - 1'b1;
      if (win_r)
        winner_q <= 2'b10;
      else if (win_l)
        winner_q <= 2'b01;
      if (state != S_WIN)
        flash <= 1'b1;
      else if (tick)
        flash <= ~flash;
    end
  end

  always_comb begin
    go         = (state == S_GO);
    match_over = (state == S_WIN);
    winner     = winner_q;
    if (state == S_WIN)
      led_out = {NLEDS{flash}};
    else
      led_out = NLEDS'(1) << pos;
  end

endmodule
